uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register so consecutive
// frames can be chained with no idle gap on the line.
module uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       i_Rst_n,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             serial_q, serial_d;
    logic             done_q, done_d;

    logic accept;
    logic bit_end;
    logic stop_end;

    assign accept   = i_TX_DV && !hold_full_q;
    assign bit_end  = (clk_cnt_q == CNT_MAX);
    assign stop_end = (state_q == STOP) && bit_end;

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (accept) begin
                    shift_d = i_TX_Byte;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    done_d    = 1'b1;
                    // A held byte wins; otherwise a strobe on this exact cycle
                    // is loaded directly so the next frame still follows back-to-back.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = START;
                    end else if (accept) begin
                        shift_d = i_TX_Byte;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
        endcase

        if (accept && (state_q != IDLE) && !stop_end) begin
            hold_d      = i_TX_Byte;
            hold_full_d = 1'b1;
        end
    end

    // The line level is registered from the next-state view so it changes
    // on the same edge as the state and never glitches.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            IDLE:  serial_d = 1'b1;
            START: serial_d = 1'b0;
            DATA:  serial_d = shift_d[0];
            STOP:  serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            serial_q    <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            serial_q    <= serial_d;
            done_q      <= done_d;
        end
    end

    assign o_TX_Ready  = !hold_full_q;
    assign o_TX_Active = (state_q != IDLE);
    assign o_TX_Serial = serial_q;
    assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: frame timing, chaining, overflow,
// stop-edge load, asynchronous reset and a mid-bit sampling receiver model.
module tb_uart_tx;

    localparam int CPB = 217;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       ready;
    logic       active;
    logic       serial;
    logic       done;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .i_Rst_n    (rst_n),
        .i_TX_DV    (dv),
        .i_TX_Byte  (tx_byte),
        .o_TX_Ready (ready),
        .o_TX_Active(active),
        .o_TX_Serial(serial),
        .o_TX_Done  (done)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_pulses++;
    end

    initial begin
        #(40 * 80000);
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected line levels of one frame, element 0 = start bit.
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Strobe one byte; returns at the negedge right after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        dv      = 1'b1;
        tx_byte = b;
        @(negedge clk);
        dv      = 1'b0;
        tx_byte = ~b;
    endtask

    // Entered at the first cycle of a frame; returns 10*CPB cycles later.
    task automatic capture_frame(output logic [9:0] first_v, output logic [9:0] last_v,
                                 output int done_cnt, output int idle_cnt, output logic end_done);
        first_v  = '0;
        last_v   = '0;
        done_cnt = 0;
        idle_cnt = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (c == 0) first_v[b] = serial;
                if (c == CPB - 1) last_v[b] = serial;
                if ((b != 0 || c != 0) && done === 1'b1) done_cnt++;
                if (active !== 1'b1) idle_cnt++;
                @(negedge clk);
            end
        end
        end_done = done;
    endtask

    task automatic idle_watch(input int n, output int low_cnt, output int act_cnt);
        low_cnt = 0;
        act_cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (serial !== 1'b1) low_cnt++;
            if (active !== 1'b0) act_cnt++;
            @(negedge clk);
        end
    endtask

    // Receiver model: find the falling edge, then sample each bit mid-period.
    task automatic rx_decode(output logic [7:0] b, output logic found, output logic framing_ok);
        int waited;
        waited     = 0;
        found      = 1'b0;
        framing_ok = 1'b0;
        b          = '0;
        while (serial !== 1'b0 && waited < 12 * CPB) begin
            @(negedge clk);
            waited++;
        end
        if (serial === 1'b0) begin
            found = 1'b1;
            repeat (CPB / 2) @(negedge clk);
            framing_ok = (serial === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = serial;
            end
            repeat (CPB) @(negedge clk);
            framing_ok = framing_ok && (serial === 1'b1);
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (serial !== 1'b1) begin errors++; $display("[TB] FAIL reset_serial: got %b expected 1", serial); end
        checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b expected 0", active); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
    endtask

    task automatic test_single;
        logic [9:0] fv, lv;
        int dc, ic;
        logic ed;
        // Release reset and strobe on the same negedge: the first edge must accept.
        @(negedge clk);
        rst_n   = 1'b1;
        dv      = 1'b1;
        tx_byte = 8'h37;
        @(negedge clk);
        dv      = 1'b0;
        tx_byte = 8'hC8;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b expected 1", ready); end
        capture_frame(fv, lv, dc, ic, ed);
        checks++; if (fv !== frame_bits(8'h37)) begin errors++; $display("[TB] FAIL single_first_cycles: got %b expected %b", fv, frame_bits(8'h37)); end
        checks++; if (lv !== frame_bits(8'h37)) begin errors++; $display("[TB] FAIL single_last_cycles: got %b expected %b", lv, frame_bits(8'h37)); end
        checks++; if (dc !== 0) begin errors++; $display("[TB] FAIL single_early_done: got %0d expected 0", dc); end
        checks++; if (ic !== 0) begin errors++; $display("[TB] FAIL single_active: got %0d inactive cycles expected 0", ic); end
        checks++; if (ed !== 1'b1) begin errors++; $display("[TB] FAIL single_done_at_2170: got %b expected 1", ed); end
        checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_active: got %b expected 0", active); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_width: got %b expected 0", done); end
        checks++; if (serial !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_serial: got %b expected 1", serial); end
    endtask

    task automatic test_chained_overflow;
        logic [9:0] fv1, lv1, fv2, lv2;
        int dc1, ic1, dc2, ic2, lowc, actc;
        logic ed1, ed2;
        logic rdy_hold, rdy_ovf, rdy_pre_stop, rdy_next;
        send_byte(8'h37);
        fork
            capture_frame(fv1, lv1, dc1, ic1, ed1);
            begin
                repeat (3 * CPB) @(negedge clk);
                dv = 1'b1; tx_byte = 8'hA5;
                @(negedge clk);
                dv = 1'b0; tx_byte = 8'h12;
                rdy_hold = ready;
                repeat (CPB) @(negedge clk);
                dv = 1'b1; tx_byte = 8'hFF;
                @(negedge clk);
                dv = 1'b0; tx_byte = 8'h00;
                rdy_ovf = ready;
                repeat (10 * CPB - 1 - (4 * CPB + 2)) @(negedge clk);
                rdy_pre_stop = ready;
            end
        join
        rdy_next = ready;
        capture_frame(fv2, lv2, dc2, ic2, ed2);
        idle_watch(3 * CPB, lowc, actc);
        checks++; if ({fv1, lv1} !== {frame_bits(8'h37), frame_bits(8'h37)}) begin errors++; $display("[TB] FAIL chain_frame1: got %b/%b expected %b", fv1, lv1, frame_bits(8'h37)); end
        checks++; if (rdy_hold !== 1'b0) begin errors++; $display("[TB] FAIL chain_ready_after_hold: got %b expected 0", rdy_hold); end
        checks++; if (rdy_ovf !== 1'b0) begin errors++; $display("[TB] FAIL chain_ready_after_overflow: got %b expected 0", rdy_ovf); end
        checks++; if (rdy_pre_stop !== 1'b0) begin errors++; $display("[TB] FAIL chain_ready_pre_stop: got %b expected 0", rdy_pre_stop); end
        checks++; if (rdy_next !== 1'b1) begin errors++; $display("[TB] FAIL chain_ready_frame2: got %b expected 1", rdy_next); end
        checks++; if ({fv2, lv2} !== {frame_bits(8'hA5), frame_bits(8'hA5)}) begin errors++; $display("[TB] FAIL chain_frame2: got %b/%b expected %b", fv2, lv2, frame_bits(8'hA5)); end
        checks++; if ({ed1, ed2} !== 2'b11) begin errors++; $display("[TB] FAIL chain_done_pulses: got %b expected 11", {ed1, ed2}); end
        checks++; if (dc1 + dc2 !== 0) begin errors++; $display("[TB] FAIL chain_extra_done: got %0d expected 0", dc1 + dc2); end
        checks++; if (ic1 + ic2 !== 0) begin errors++; $display("[TB] FAIL chain_active_gap: got %0d expected 0", ic1 + ic2); end
        checks++; if (lowc + actc !== 0) begin errors++; $display("[TB] FAIL chain_overflow_frame: got %0d busy cycles expected 0", lowc + actc); end
    endtask

    task automatic test_stop_edge_load;
        logic [9:0] fv1, lv1, fv2, lv2;
        int dc1, ic1, dc2, ic2, lowc, actc;
        logic ed1, ed2, rdy_stop;
        send_byte(8'h37);
        fork
            capture_frame(fv1, lv1, dc1, ic1, ed1);
            begin
                repeat (10 * CPB - 1) @(negedge clk);
                rdy_stop = ready;
                dv = 1'b1; tx_byte = 8'h55;
                @(negedge clk);
                dv = 1'b0; tx_byte = 8'hAA;
            end
        join
        capture_frame(fv2, lv2, dc2, ic2, ed2);
        idle_watch(3 * CPB, lowc, actc);
        checks++; if (rdy_stop !== 1'b1) begin errors++; $display("[TB] FAIL stopload_ready: got %b expected 1", rdy_stop); end
        checks++; if ({fv1, lv1} !== {frame_bits(8'h37), frame_bits(8'h37)}) begin errors++; $display("[TB] FAIL stopload_frame1: got %b/%b expected %b", fv1, lv1, frame_bits(8'h37)); end
        checks++; if ({fv2, lv2} !== {frame_bits(8'h55), frame_bits(8'h55)}) begin errors++; $display("[TB] FAIL stopload_frame2: got %b/%b expected %b", fv2, lv2, frame_bits(8'h55)); end
        checks++; if ({ed1, ed2, dc1 == 0, dc2 == 0} !== 4'b1111) begin errors++; $display("[TB] FAIL stopload_done: got %b expected 1111", {ed1, ed2, dc1 == 0, dc2 == 0}); end
        checks++; if (ic1 + ic2 !== 0) begin errors++; $display("[TB] FAIL stopload_active_gap: got %0d expected 0", ic1 + ic2); end
        checks++; if (lowc + actc !== 0) begin errors++; $display("[TB] FAIL stopload_extra_frame: got %0d busy cycles expected 0", lowc + actc); end
    endtask

    task automatic test_reset_mid_data;
        logic [9:0] fv, lv;
        int dc, ic, lowc, actc, done_rst;
        logic ed, pre_serial;
        logic [3:0] rst_outs;
        send_byte(8'h00);
        repeat (CPB) @(negedge clk);
        dv = 1'b1; tx_byte = 8'h99;
        @(negedge clk);
        dv = 1'b0; tx_byte = 8'h00;
        repeat (5 * CPB + CPB / 2 - (CPB + 1)) @(negedge clk);
        pre_serial = serial;
        #5 rst_n = 1'b0;
        #1 rst_outs = {serial, active, ready, done};
        done_rst = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) done_rst++;
        end
        rst_n   = 1'b1;
        dv      = 1'b1;
        tx_byte = 8'hC3;
        @(negedge clk);
        dv      = 1'b0;
        tx_byte = 8'h3C;
        capture_frame(fv, lv, dc, ic, ed);
        idle_watch(3 * CPB, lowc, actc);
        checks++; if (pre_serial !== 1'b0) begin errors++; $display("[TB] FAIL rst_pre_serial: got %b expected 0", pre_serial); end
        checks++; if (rst_outs !== 4'b1010) begin errors++; $display("[TB] FAIL rst_async_outputs: got %b expected 1010", rst_outs); end
        checks++; if (done_rst !== 0) begin errors++; $display("[TB] FAIL rst_no_done: got %0d expected 0", done_rst); end
        checks++; if ({fv, lv} !== {frame_bits(8'hC3), frame_bits(8'hC3)}) begin errors++; $display("[TB] FAIL rst_after_frame: got %b/%b expected %b", fv, lv, frame_bits(8'hC3)); end
        checks++; if ({ed, dc == 0, ic == 0} !== 3'b111) begin errors++; $display("[TB] FAIL rst_after_done: got %b expected 111", {ed, dc == 0, ic == 0}); end
        checks++; if (lowc + actc !== 0) begin errors++; $display("[TB] FAIL rst_held_byte_leaked: got %0d busy cycles expected 0", lowc + actc); end
    endtask

    task automatic test_loopback;
        logic [7:0] msgs [4];
        logic [7:0] got  [4];
        logic       fnd  [4];
        logic       frm  [4];
        int  drv_timeouts, pulses_before, waited;
        msgs = '{8'h00, 8'hFF, 8'h55, 8'h37};
        drv_timeouts  = 0;
        pulses_before = done_pulses;
        fork
            begin
                send_byte(msgs[0]);
                for (int k = 1; k < 4; k++) begin
                    waited = 0;
                    while (ready !== 1'b1 && waited < 12 * CPB) begin
                        @(negedge clk);
                        waited++;
                    end
                    if (ready !== 1'b1) drv_timeouts++;
                    send_byte(msgs[k]);
                end
            end
            begin
                for (int k = 0; k < 4; k++) rx_decode(got[k], fnd[k], frm[k]);
            end
        join
        repeat (CPB) @(negedge clk);
        checks++; if (drv_timeouts !== 0) begin errors++; $display("[TB] FAIL loop_ready_timeout: got %0d expected 0", drv_timeouts); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== msgs[k] || fnd[k] !== 1'b1 || frm[k] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL loop_byte%0d: got %h (found %b framing %b) expected %h", k, got[k], fnd[k], frm[k], msgs[k]);
            end
        end
        checks++; if (done_pulses - pulses_before !== 4) begin errors++; $display("[TB] FAIL loop_done_count: got %0d expected 4", done_pulses - pulses_before); end
    endtask

    initial begin
        $display("[TB] uart_tx bench, CLKS_PER_BIT=%0d", CPB);
        test_reset();
        test_single();
        test_chained_overflow();
        test_stop_edge_load();
        test_reset_mid_data();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
